vga_timing_gen: RTL and testbench

- Generates the raster scan that drives the sprite renderers: pixel coordinates hc/vc, blank, hsync and vsync.
- Default timing is 640x480@60 Hz from a 100 MHz system clock.
- Pixel rate is a divided clock-enable, so the pixel-ROM read latency (one system clock) is hidden inside each pixel period.
- Sits between the board clock and every sprite/overlay block and the VGA pins.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_axis_counter.sv | 49 ++++
 rtl/vga_timing_gen.sv | 79 +++++++
 tb/tb_vga_timing_gen.sv | 115 +++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA raster constants, totals and colour widths
package vga_timing_pkg;

   localparam int CNT_W = 11;

   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FP      = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BP      = 48;
   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FP      = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BP      = 33;
   localparam int DEF_PIX_DIV   = 4;
   localparam bit DEF_SYNC_ACTIVE = 1'b0;

   function automatic int axis_total(input int vis, input int fp, input int sync, input int bp);
      return vis + fp + sync + bp;
   endfunction

   localparam int H_TOTAL = axis_total(DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
   localparam int V_TOTAL = axis_total(DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

   localparam int R_W   = 3;
   localparam int G_W   = 3;
   localparam int B_W   = 2;
   localparam int RGB_W = R_W + G_W + B_W;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping position counter with blank/sync decode
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int VISIBLE     = DEF_H_VISIBLE,
   parameter int FP          = DEF_H_FP,
   parameter int SYNC        = DEF_H_SYNC,
   parameter int BP          = DEF_H_BP,
   parameter bit SYNC_ACTIVE = DEF_SYNC_ACTIVE
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             adv,
   output logic [CNT_W-1:0] count,
   output logic             wrap,
   output logic             blank_axis,
   output logic             sync_axis
);

   localparam logic [CNT_W-1:0] LAST       = CNT_W'(axis_total(VISIBLE, FP, SYNC, BP) - 1);
   localparam logic [CNT_W-1:0] VIS_END    = CNT_W'(VISIBLE);
   localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(VISIBLE + FP);
   localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(VISIBLE + FP + SYNC);

   logic [CNT_W-1:0] count_nxt;

   assign wrap = adv && (count == LAST);

   always_comb begin
      count_nxt = count;
      if (adv) begin
         count_nxt = (count == LAST) ? '0 : count + 1'b1;
      end
   end

   // Decodes are taken from the next count so they change in the same clock as count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count      <= '0;
         blank_axis <= 1'b0;
         sync_axis  <= ~SYNC_ACTIVE;
      end else begin
         count      <= count_nxt;
         blank_axis <= (count_nxt >= VIS_END);
         sync_axis  <= ((count_nxt >= SYNC_START) && (count_nxt < SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster generator; VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE   = DEF_H_VISIBLE,
   parameter int H_FP        = DEF_H_FP,
   parameter int H_SYNC      = DEF_H_SYNC,
   parameter int H_BP        = DEF_H_BP,
   parameter int V_VISIBLE   = DEF_V_VISIBLE,
   parameter int V_FP        = DEF_V_FP,
   parameter int V_SYNC      = DEF_V_SYNC,
   parameter int V_BP        = DEF_V_BP,
   parameter int PIX_DIV     = DEF_PIX_DIV,
   parameter bit SYNC_ACTIVE = DEF_SYNC_ACTIVE
)(
   input  logic             clk,
   input  logic             rst,
   output logic [CNT_W-1:0] hc,
   output logic [CNT_W-1:0] vc,
   output logic             blank,
   output logic             hsync,
   output logic             vsync,
   output logic             pix_en,
   output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,
   output logic [15:0]      frame_cnt
`endif
);

   localparam int DIV_W = $clog2(PIX_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

   logic [DIV_W-1:0] div, div_nxt;
   logic tick, h_wrap, v_wrap, h_blank, v_blank;

   assign tick    = (div == DIV_LAST);
   assign div_nxt = tick ? '0 : div + 1'b1;

   // pix_en is high during the last clock of a pixel; the raster steps at the end of it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div         <= '0;
         pix_en      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         div         <= div_nxt;
         pix_en      <= (div_nxt == DIV_LAST);
         frame_start <= h_wrap & v_wrap;
      end
   end

   vga_axis_counter #(
      .VISIBLE(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_ACTIVE(SYNC_ACTIVE)
   ) u_h_axis (
      .clk(clk), .rst(rst), .adv(tick),
      .count(hc), .wrap(h_wrap), .blank_axis(h_blank), .sync_axis(hsync)
   );

   vga_axis_counter #(
      .VISIBLE(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_ACTIVE(SYNC_ACTIVE)
   ) u_v_axis (
      .clk(clk), .rst(rst), .adv(h_wrap),
      .count(vc), .wrap(v_wrap), .blank_axis(v_blank), .sync_axis(vsync)
   );

   assign blank = h_blank | v_blank;

`ifdef VGA_TIMING_FRAME_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt <= '0;
      end else if (h_wrap & v_wrap) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized reset/run bench for vga_timing_gen against an arithmetic raster model
module tb_vga_timing_gen;

   localparam int HV = 8, HF = 2, HS = 3, HB = 2;
   localparam int VV = 5, VF = 1, VS = 2, VB = 2;
   localparam int PD = 3;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] hc, vc;
   logic        blank, hsync, vsync, pix_en, frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int t = 0;
   int cnt_off = 0;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .PIX_DIV(PD), .SYNC_ACTIVE(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .hc(hc), .vc(vc), .blank(blank),
      .hsync(hsync), .vsync(vsync), .pix_en(pix_en), .frame_start(frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_cnt(frame_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s t=%0d observed %0d expected %0d", tag, t, obs, exp);
      end
   endtask

   // Raster derived from elapsed system clocks since reset release.
   task automatic check_all();
      int p, d, ehc, evc;
      p   = t / PD;
      d   = t % PD;
      ehc = p % HT;
      evc = (p / HT) % VT;
      chk("hc", 32'(hc), 32'(ehc));
      chk("vc", 32'(vc), 32'(evc));
      chk("blank", 32'(blank), 32'((ehc >= HV) || (evc >= VV)));
      chk("hsync", 32'(hsync), 32'(!((ehc >= HV + HF) && (ehc < HV + HF + HS))));
      chk("vsync", 32'(vsync), 32'(!((evc >= VV + VF) && (evc < VV + VF + VS))));
      chk("pix_en", 32'(pix_en), 32'(d == PD - 1));
      chk("frame_start", 32'(frame_start), 32'((t > 0) && (d == 0) && (p % FRAME == 0)));
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk("frame_cnt", 32'(frame_cnt), 32'(((p / FRAME) + cnt_off) & 16'hffff));
`endif
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         if (!rst) t++;
         @(negedge clk);
         check_all();
      end
   endtask

   task automatic do_reset(input int hold);
      @(negedge clk);
      rst = 1'b1;
      #1;
      t = 0;
      cnt_off = 0;
      check_all();
      step(hold);
      rst = 1'b0;
      check_all();
   endtask

   initial begin
      step(3);
      rst = 1'b0;
      check_all();
      step(2 * FRAME * PD + 20);

      for (int k = 0; k < 8; k++) begin
         step($urandom_range(1, 700));
         do_reset($urandom_range(1, 3));
      end

      do_reset(3);
      step(3 * FRAME * PD);
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk("three_frames", 32'(frame_cnt), 32'd3);
      step(5);
      force dut.frame_cnt = 16'hffff;
      #1;
      release dut.frame_cnt;
      cnt_off = 65535 - (t / PD) / FRAME;
      step(FRAME * PD);
      chk("cnt_wrap", 32'(frame_cnt), 32'd0);
`endif
      chk("frames_seen_vc", 32'(vc), 32'(((t / PD) / HT) % VT));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
